// File: rtl/proc_pkg.sv
// Shared opcode, ALU-op and phase encodings for the 4-bit processor control path.
// Also holds the per-opcode datapath control decode used during EXEC.
package proc_pkg;

  localparam logic [3:0] OP_JC    = 4'b0000;
  localparam logic [3:0] OP_JNC   = 4'b0001;
  localparam logic [3:0] OP_CMPI  = 4'b0010;
  localparam logic [3:0] OP_CMPM  = 4'b0011;
  localparam logic [3:0] OP_LIT   = 4'b0100;
  localparam logic [3:0] OP_IN    = 4'b0101;
  localparam logic [3:0] OP_LD    = 4'b0110;
  localparam logic [3:0] OP_ST    = 4'b0111;
  localparam logic [3:0] OP_JZ    = 4'b1000;
  localparam logic [3:0] OP_JNZ   = 4'b1001;
  localparam logic [3:0] OP_ADDI  = 4'b1010;
  localparam logic [3:0] OP_ADDM  = 4'b1011;
  localparam logic [3:0] OP_JMP   = 4'b1100;
  localparam logic [3:0] OP_OUT   = 4'b1101;
  localparam logic [3:0] OP_NANDI = 4'b1110;
  localparam logic [3:0] OP_NANDM = 4'b1111;

  localparam logic [1:0] ALU_PASS_B = 2'b00;
  localparam logic [1:0] ALU_ADD    = 2'b01;
  localparam logic [1:0] ALU_SUB    = 2'b10;
  localparam logic [1:0] ALU_NAND   = 2'b11;

  typedef enum logic [1:0] {
    PH_IDLE  = 2'b00,
    PH_FETCH = 2'b01,
    PH_EXEC  = 2'b10
  } phase_t;

  typedef struct packed {
    logic [1:0] alu_op;
    logic       src_mem;
    logic       acc_we;
    logic       flags_we;
    logic       mem_we;
    logic       out_we;
    logic       in_sel;
  } ctrl_t;

  // Jumps decode to all-zero here; their PC strobes come from jump_cond.
  function automatic ctrl_t decode_op(input logic [3:0] op);
    ctrl_t c;
    c = '0;
    case (op)
      OP_LIT:   c.acc_we = 1'b1;
      OP_LD:    begin c.acc_we = 1'b1; c.src_mem = 1'b1; end
      OP_IN:    begin c.acc_we = 1'b1; c.in_sel = 1'b1; end
      OP_ST:    c.mem_we = 1'b1;
      OP_OUT:   c.out_we = 1'b1;
      OP_ADDI:  begin c.acc_we = 1'b1; c.flags_we = 1'b1; c.alu_op = ALU_ADD; end
      OP_ADDM:  begin c.acc_we = 1'b1; c.flags_we = 1'b1; c.alu_op = ALU_ADD; c.src_mem = 1'b1; end
      OP_CMPI:  begin c.flags_we = 1'b1; c.alu_op = ALU_SUB; end
      OP_CMPM:  begin c.flags_we = 1'b1; c.alu_op = ALU_SUB; c.src_mem = 1'b1; end
      OP_NANDI: begin c.acc_we = 1'b1; c.alu_op = ALU_NAND; end
      OP_NANDM: begin c.acc_we = 1'b1; c.alu_op = ALU_NAND; c.src_mem = 1'b1; end
      default:  c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/jump_cond.sv
// Combinational jump classifier: flags whether instr is a jump and whether it is taken
// given the registered carry/zero flags.
module jump_cond
  import proc_pkg::*;
(
  input  logic [3:0] instr,
  input  logic       c_flag,
  input  logic       z_flag,
  output logic       is_jump,
  output logic       taken
);

  always_comb begin
    is_jump = 1'b1;
    taken   = 1'b0;
    case (instr)
      OP_JC:   taken = c_flag;
      OP_JNC:  taken = ~c_flag;
      OP_JZ:   taken = z_flag;
      OP_JNZ:  taken = ~z_flag;
      OP_JMP:  taken = 1'b1;
      default: is_jump = 1'b0;
    endcase
  end

endmodule

// File: rtl/fetch_exec_sequencer.sv
// FETCH/EXEC control FSM for the 4-bit processor; strobes are valid for exactly one cycle.
// Optional macro SINGLE_STEP_EN lets a one-cycle step pulse run a single instruction from IDLE.
module fetch_exec_sequencer
  import proc_pkg::*;
#(
  parameter int PC_W  = 12,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             step,
  input  logic [3:0]       instr,
  input  logic [3:0]       oprnd,
  input  logic [7:0]       prog_byte,
  input  logic             c_flag,
  input  logic             z_flag,
  output logic             enable_pc,
  output logic             load_pc,
  output logic [PC_W-1:0]  pc_target,
  output logic             enable_fetch,
  output logic [1:0]       alu_op,
  output logic             src_mem,
  output logic             acc_we,
  output logic             flags_we,
  output logic             mem_we,
  output logic             out_we,
  output logic             in_sel,
  output logic [1:0]       phase,
  output logic [CNT_W-1:0] retired
);

  phase_t           r_state;
  phase_t           w_next;
  logic [CNT_W-1:0] r_retired;
  logic             w_is_jump;
  logic             w_taken;
  logic             w_start;
  ctrl_t            w_ctrl;

  jump_cond u_jump_cond (
    .instr   (instr),
    .c_flag  (c_flag),
    .z_flag  (z_flag),
    .is_jump (w_is_jump),
    .taken   (w_taken)
  );

`ifdef SINGLE_STEP_EN
  assign w_start = run | step;
`else
  logic w_unused_step;
  assign w_unused_step = step;
  assign w_start       = run;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= PH_IDLE;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == PH_EXEC) r_retired <= r_retired + CNT_W'(1);
    end
  end

  // Outputs decode from the state register, so an async reset clears them in the same cycle.
  always_comb begin
    w_next       = r_state;
    w_ctrl       = '0;
    enable_pc    = 1'b0;
    load_pc      = 1'b0;
    pc_target    = '0;
    enable_fetch = 1'b0;
    case (r_state)
      PH_IDLE: begin
        if (w_start) w_next = PH_FETCH;
      end
      PH_FETCH: begin
        enable_fetch = 1'b1;
        enable_pc    = 1'b1;
        w_next       = PH_EXEC;
      end
      PH_EXEC: begin
        w_ctrl = decode_op(instr);
        if (w_is_jump) begin
          if (w_taken) begin
            load_pc   = 1'b1;
            pc_target = PC_W'({oprnd, prog_byte});
          end else begin
            enable_pc = 1'b1;
          end
        end
        w_next = run ? PH_FETCH : PH_IDLE;
      end
      default: w_next = PH_IDLE;
    endcase
  end

  assign alu_op   = w_ctrl.alu_op;
  assign src_mem  = w_ctrl.src_mem;
  assign acc_we   = w_ctrl.acc_we;
  assign flags_we = w_ctrl.flags_we;
  assign mem_we   = w_ctrl.mem_we;
  assign out_we   = w_ctrl.out_we;
  assign in_sel   = w_ctrl.in_sel;
  assign phase    = r_state;
  assign retired  = r_retired;

endmodule

// File: tb/tb_fetch_exec_sequencer.sv
// Randomized self-checking bench for fetch_exec_sequencer against an opcode-table reference model.
// Compile with +define+SINGLE_STEP_EN to also exercise single-step.
module tb_fetch_exec_sequencer;

  logic        clk = 1'b0;
  logic        reset, run, step, c_flag, z_flag;
  logic [3:0]  instr, oprnd;
  logic [7:0]  prog_byte;
  logic        enable_pc, load_pc, enable_fetch, src_mem, acc_we, flags_we, mem_we, out_we, in_sel;
  logic [11:0] pc_target;
  logic [1:0]  alu_op, phase;
  logic [15:0] retired;

  int n_checks = 0;
  int n_errors = 0;

`ifdef SINGLE_STEP_EN
  localparam bit STEP_EN = 1'b1;
`else
  localparam bit STEP_EN = 1'b0;
`endif

  // Reference model: 0 idle, 1 fetch, 2 exec; retired as plain integer modulo 2^16.
  int          m_phase = 0;
  int unsigned m_ret   = 0;

  // Snapshot of the last sampled cycle for targeted checks.
  logic        last_epc, last_load, last_fl, last_acc;
  logic [11:0] last_tgt;
  logic [1:0]  last_ph;

  fetch_exec_sequencer dut (
    .clk(clk), .reset(reset), .run(run), .step(step), .instr(instr), .oprnd(oprnd),
    .prog_byte(prog_byte), .c_flag(c_flag), .z_flag(z_flag), .enable_pc(enable_pc),
    .load_pc(load_pc), .pc_target(pc_target), .enable_fetch(enable_fetch), .alu_op(alu_op),
    .src_mem(src_mem), .acc_we(acc_we), .flags_we(flags_we), .mem_we(mem_we), .out_we(out_we),
    .in_sel(in_sel), .phase(phase), .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected packed outputs: {epc, load, tgt[11:0], ef, alu[1:0], srcm, acc, flg, mem, out, in, phase[1:0]}
  function automatic logic [24:0] model_outs(input logic [3:0] op, input logic [3:0] od,
                                             input logic [7:0] pb, input logic c, input logic z);
    logic epc, ld, ef, sm, aw, fw, mw, ow, is_;
    logic [11:0] tgt;
    logic [1:0] alu, ph;
    bit jmp, tk;
    {epc, ld, ef, sm, aw, fw, mw, ow, is_} = '0;
    tgt = 12'h000; alu = 2'b00; ph = 2'(m_phase);
    if (m_phase == 1) begin
      ef = 1; epc = 1;
    end else if (m_phase == 2) begin
      jmp = (op == 4'h0 || op == 4'h1 || op == 4'h8 || op == 4'h9 || op == 4'hC);
      tk  = (op == 4'h0 && c) || (op == 4'h1 && !c) || (op == 4'h8 && z) ||
            (op == 4'h9 && !z) || (op == 4'hC);
      if (jmp && tk) begin ld = 1; tgt = {od, pb}; end
      else if (jmp) epc = 1;
      aw  = (op inside {4'h4, 4'h5, 4'h6, 4'hA, 4'hB, 4'hE, 4'hF});
      fw  = (op inside {4'h2, 4'h3, 4'hA, 4'hB});
      sm  = (op inside {4'h3, 4'h6, 4'hB, 4'hF});
      mw  = (op == 4'h7);
      ow  = (op == 4'hD);
      is_ = (op == 4'h5);
      if (op inside {4'hA, 4'hB}) alu = 2'd1;
      else if (op inside {4'h2, 4'h3}) alu = 2'd2;
      else if (op inside {4'hE, 4'hF}) alu = 2'd3;
    end
    return {epc, ld, tgt, ef, alu, sm, aw, fw, mw, ow, is_, ph};
  endfunction

  task automatic cycle(input bit rs, input bit rn, input bit st, input logic [3:0] op,
                       input logic [3:0] od, input logic [7:0] pb, input bit c, input bit z);
    @(negedge clk);
    reset = rs; run = rn; step = st; instr = op; oprnd = od; prog_byte = pb;
    c_flag = c; z_flag = z;
    #1;
    if (!rs) begin m_phase = 0; m_ret = 0; end
    check("outputs", {7'd0, enable_pc, load_pc, pc_target, enable_fetch, alu_op, src_mem,
                      acc_we, flags_we, mem_we, out_we, in_sel, phase},
          {7'd0, model_outs(op, od, pb, c, z)});
    check("retired", {16'd0, retired}, m_ret & 32'hFFFF);
    last_epc = enable_pc; last_load = load_pc; last_tgt = pc_target;
    last_fl = flags_we; last_acc = acc_we; last_ph = phase;
    @(posedge clk);
    if (rs) begin
      case (m_phase)
        0: if (rn || (STEP_EN && st)) m_phase = 1;
        1: m_phase = 2;
        default: begin m_ret = (m_ret + 1) & 32'hFFFF; m_phase = rn ? 1 : 0; end
      endcase
    end
  endtask

  initial begin
    int unsigned r0;
    reset = 1'b0; run = 1'b1; step = 1'b0; instr = 4'h0; oprnd = 4'h0;
    prog_byte = 8'h00; c_flag = 1'b0; z_flag = 1'b0;

    // Reset held with run=1: stays IDLE with all outputs low.
    repeat (3) cycle(0, 1, 0, 4'hC, 4'hF, 8'hFF, 1, 1);
    check("rst_phase", {30'd0, last_ph}, 32'd0);
    cycle(1, 1, 0, 4'h4, 4'h5, 8'h00, 0, 0);
    #1 check("rel_fetch", {30'd0, phase}, 32'd1);

    // LIT 5 then ADDI 3.
    cycle(1, 1, 0, 4'h4, 4'h5, 8'h00, 0, 0);
    cycle(1, 1, 0, 4'h4, 4'h5, 8'h00, 0, 0);
    check("lit_acc", {31'd0, last_acc}, 32'd1);
    check("lit_flg", {31'd0, last_fl}, 32'd0);
    cycle(1, 1, 0, 4'hA, 4'h3, 8'h00, 0, 0);
    cycle(1, 1, 0, 4'hA, 4'h3, 8'h00, 0, 0);
    check("addi_flg", {31'd0, last_fl}, 32'd1);
    #1 check("retired2", {16'd0, retired}, 32'd2);

    // JMP 0x32A.
    cycle(1, 1, 0, 4'hC, 4'h3, 8'h2A, 0, 0);
    cycle(1, 1, 0, 4'hC, 4'h3, 8'h2A, 0, 0);
    check("jmp_load", {31'd0, last_load}, 32'd1);
    check("jmp_tgt", {20'd0, last_tgt}, 32'h32A);
    check("jmp_epc", {31'd0, last_epc}, 32'd0);

    // JZ not taken, then taken.
    cycle(1, 1, 0, 4'h8, 4'h7, 8'h11, 1, 0);
    cycle(1, 1, 0, 4'h8, 4'h7, 8'h11, 1, 0);
    check("jz_nt_epc", {31'd0, last_epc}, 32'd1);
    check("jz_nt_load", {31'd0, last_load}, 32'd0);
    check("jz_nt_tgt", {20'd0, last_tgt}, 32'd0);
    cycle(1, 1, 0, 4'h8, 4'h0, 8'hB4, 0, 1);
    cycle(1, 1, 0, 4'h8, 4'h0, 8'hB4, 0, 1);
    check("jz_t_tgt", {20'd0, last_tgt}, 32'h0B4);

    // Drop run during FETCH of CMPI: completes, then parks in IDLE.
    cycle(1, 0, 0, 4'h2, 4'h9, 8'h00, 0, 0);
    cycle(1, 0, 0, 4'h2, 4'h9, 8'h00, 0, 0);
    check("cmpi_flg", {31'd0, last_fl}, 32'd1);
    check("cmpi_acc", {31'd0, last_acc}, 32'd0);
    repeat (3) cycle(1, 0, 0, 4'h4, 4'h1, 8'h00, 0, 0);
    check("idle_stay", {30'd0, last_ph}, 32'd0);

    // Reset asserted during EXEC clears outputs immediately.
    cycle(1, 1, 0, 4'hA, 4'h1, 8'h00, 0, 0);
    cycle(1, 1, 0, 4'hA, 4'h1, 8'h00, 0, 0);
    cycle(0, 1, 0, 4'hA, 4'h1, 8'h00, 0, 0);
    check("rst_exec_flg", {31'd0, last_fl}, 32'd0);
    cycle(1, 0, 0, 4'h0, 4'h0, 8'h00, 0, 0);

`ifdef SINGLE_STEP_EN
    r0 = 32'(retired);
    cycle(1, 0, 1, 4'h7, 4'h2, 8'h00, 0, 0);
    repeat (4) cycle(1, 0, 0, 4'h7, 4'h2, 8'h00, 0, 0);
    check("step_ret", {16'd0, retired}, (r0 + 1) & 32'hFFFF);
    check("step_idle", {30'd0, last_ph}, 32'd0);
`else
    r0 = 32'(retired);
    cycle(1, 0, 1, 4'h7, 4'h2, 8'h00, 0, 0);
    repeat (4) cycle(1, 0, 0, 4'h7, 4'h2, 8'h00, 0, 0);
    check("step_ignored", {16'd0, retired}, r0);
`endif

    // Randomized traffic with occasional mid-flight resets.
    for (int i = 0; i < 800; i++) begin
      cycle(($urandom_range(0, 59) != 0), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 7) == 0), 4'($urandom), 4'($urandom), 8'($urandom),
            1'($urandom), 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
